pe_array_out_collector: RTL

- Drain-side companion to the 1D FP16 systolic PE array. The array is free-running; this block decides which `PE_Array_out` cycles carry finished convolution results for the active `filter_size`/`stride`.
- Captured results go into a small FIFO and are handed downstream with valid/ready.
- Sits between `PE_Array_out` and the output buffer/writeback.
- Runs in lockstep with the A-stream feeder, using its `a_valid` strobe.

---
 rtl/pe_array_pkg.sv | 32 +++
 rtl/pe_array_out_collector_result_fifo.sv | 83 ++++++++
 rtl/pe_array_out_collector.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared constants, types and config helpers for the PE array drain side
package pe_array_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int MAX_FILTER = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } collector_state_t;

    localparam logic [15:0] FP16_ZERO     = 16'h0000;
    localparam int          FP16_SIGN_BIT = 15;

    // Out-of-range tap counts fold onto the nearest legal value (0 -> 1, >5 -> 5).
    function automatic logic [2:0] norm_filter_size(input logic [2:0] fs);
        if (fs == 3'd0) begin
            return 3'd1;
        end
        if (fs > 3'(MAX_FILTER)) begin
            return 3'(MAX_FILTER);
        end
        return fs;
    endfunction

    // A stride of 0 would never advance; treat it as 1.
    function automatic logic [2:0] norm_stride(input logic [2:0] st);
        return (st == 3'd0) ? 3'd1 : st;
    endfunction

endpackage

// File: rtl/pe_array_out_collector_result_fifo.sv
// rtl/pe_array_out_collector_result_fifo.sv - result FIFO with a last side bit and registered head
//
// Purpose: holds captured results until downstream accepts them. A push on a
// full FIFO succeeds when a pop happens in the same cycle; otherwise it is
// ignored (the caller flags the drop).
// Ports:
//   clk, reset            clock, synchronous active-high reset (empties the FIFO)
//   push, push_data/last  write request and payload
//   pop                   read request (ignored when empty)
//   head_data/head_last   registered copy of the oldest entry
//   full, empty           occupancy flags
module result_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      mem_last;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         rd_ptr_next;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign full        = (count == AW1'(DEPTH));
    assign empty       = (count == '0);
    assign do_pop      = pop && !empty;
    assign do_push     = push && (!full || do_pop);
    assign rd_ptr_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr]      <= push_data;
            mem_last[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
            head_last <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_next;
            case ({do_push, do_pop})
                2'b10:   count <= count + AW1'(1);
                2'b01:   count <= count - AW1'(1);
                default: count <= count;
            endcase
            // The head register tracks the entry at the next read pointer. When
            // that slot is being written this cycle the memory still holds the
            // old value, so the incoming word is forwarded instead.
            if (do_push && (wr_ptr == rd_ptr_next)) begin
                head_data <= push_data;
                head_last <= push_last;
            end else if (do_pop) begin
                head_data <= mem[rd_ptr_next];
                head_last <= mem_last[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/pe_array_out_collector.sv
// rtl/pe_array_out_collector.sv - picks finished convolution results out of the free-running PE array output
//
// Purpose: counts A-stream samples of one row, flags the samples whose
// PE_Array_out value (PIPE_LAT cycles later) is a finished output for the
// latched filter_size/stride, and queues those values for downstream.
// Optional feature macro: COLLECTOR_RELU_EN (negative-signed values pushed as +0).
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   start                              config latch pulse, honoured only in IDLE
//   filter_size, stride, in_len        row configuration
//   a_valid                            feeder drove a sample this cycle
//   PE_Array_out                       array output
//   out_data/out_valid/out_ready/out_last  result stream
//   busy, done, overflow               status (done one-cycle, overflow sticky)
module pe_array_out_collector #(
    parameter int DATA_WIDTH = pe_array_pkg::DATA_WIDTH,
    parameter int PIPE_LAT   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            filter_size,
    input  logic [2:0]            stride,
    input  logic [LEN_W-1:0]      in_len,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] PE_Array_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    import pe_array_pkg::*;

    localparam int DCW = $clog2(PIPE_LAT + 2);

    collector_state_t      state;
    collector_state_t      state_next;

    logic [2:0]            fs_r;
    logic [2:0]            stride_r;
    logic [2:0]            phase;
    logic [LEN_W-1:0]      in_len_r;
    logic [LEN_W-1:0]      n_out_r;
    logic [LEN_W-1:0]      idx;
    logic [LEN_W-1:0]      issued;
    logic                  skip_lat;
    logic [DCW-1:0]        drain_cnt;
    logic [PIPE_LAT-1:0]   sr_flag;
    logic [PIPE_LAT-1:0]   sr_last;

    logic [2:0]            fs_norm;
    logic [2:0]            stride_norm;
    logic                  short_row;
    logic [LEN_W-1:0]      n_out_calc;
    logic                  start_ok;
    logic                  sample;
    logic                  past_warmup;
    logic                  cap_flag;
    logic                  cap_last;
    logic                  last_sample;
    logic                  drain_exit;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_drop;
    logic [DATA_WIDTH-1:0] push_data;

    assign fs_norm     = norm_filter_size(filter_size);
    assign stride_norm = norm_stride(stride);
    assign short_row   = (in_len < LEN_W'(fs_norm));
    assign n_out_calc  = short_row ? '0
                       : (in_len - LEN_W'(fs_norm)) / LEN_W'(stride_norm) + LEN_W'(1);

    assign start_ok    = start && (state == IDLE);
    assign sample      = (state == RUN) && a_valid;
    assign past_warmup = (idx >= LEN_W'(fs_r) - LEN_W'(1));
    assign cap_flag    = sample && past_warmup && (phase == 3'd0) && (issued < n_out_r);
    assign cap_last    = (issued == n_out_r - LEN_W'(1));
    assign last_sample = sample && (idx == in_len_r - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        drain_exit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = short_row ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (last_sample) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Rows with no outputs have nothing in flight, so the pipeline
                // wait is skipped for them.
                if ((skip_lat || (drain_cnt >= DCW'(PIPE_LAT))) && fifo_empty) begin
                    state_next = IDLE;
                    drain_exit = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_r      <= 3'd1;
            stride_r  <= 3'd1;
            in_len_r  <= '0;
            n_out_r   <= '0;
            skip_lat  <= 1'b0;
            idx       <= '0;
            issued    <= '0;
            phase     <= 3'd0;
            drain_cnt <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= drain_exit;
            if (start_ok) begin
                fs_r      <= fs_norm;
                stride_r  <= stride_norm;
                in_len_r  <= in_len;
                n_out_r   <= n_out_calc;
                skip_lat  <= short_row;
                idx       <= '0;
                issued    <= '0;
                phase     <= 3'd0;
                drain_cnt <= '0;
                overflow  <= 1'b0;
            end else begin
                if (fifo_drop) begin
                    overflow <= 1'b1;
                end
                if (sample) begin
                    idx <= idx + LEN_W'(1);
                    // Stride phase: 0 marks an output-aligned sample, then
                    // counts down stride-1 skipped samples before the next one.
                    if (past_warmup) begin
                        phase <= (phase == 3'd0) ? stride_r - 3'd1 : phase - 3'd1;
                    end
                    if (cap_flag) begin
                        issued <= issued + LEN_W'(1);
                    end
                end
                if ((state == DRAIN) && (drain_cnt < DCW'(PIPE_LAT))) begin
                    drain_cnt <= drain_cnt + DCW'(1);
                end
            end
        end
    end

    // Delay line aligning the capture decision with the array latency; it
    // advances every clock because the array itself never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_flag <= '0;
            sr_last <= '0;
        end else begin
            sr_flag[0] <= cap_flag;
            sr_last[0] <= cap_flag && cap_last;
            for (int k = 1; k < PIPE_LAT; k++) begin
                sr_flag[k] <= sr_flag[k-1];
                sr_last[k] <= sr_last[k-1];
            end
        end
    end

`ifdef COLLECTOR_RELU_EN
    assign push_data = PE_Array_out[FP16_SIGN_BIT] ? DATA_WIDTH'(FP16_ZERO) : PE_Array_out;
`else
    assign push_data = PE_Array_out;
`endif

    assign fifo_push = sr_flag[PIPE_LAT-1];
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_drop = fifo_push && fifo_full && !fifo_pop;
    assign busy      = (state != IDLE);

    result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_data),
        .push_last (sr_last[PIPE_LAT-1]),
        .pop       (fifo_pop),
        .head_data (out_data),
        .head_last (out_last),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
